// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte controller.
package usb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        RECV = 2'b10,
        ERR  = 2'b11
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_SYNC    = 2'b00,
        ERR_STUFF   = 2'b01,
        ERR_EOP     = 2'b10,
        ERR_OVERRUN = 2'b11
    } rx_err_t;

    localparam logic [7:0]  SYNC_BYTE   = 8'h80;
    localparam int unsigned STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_rx_byte_ctrl_if.sv
// Receive-side handshake bundle: bit-level inputs from the decoder, byte-level outputs to the FIFO.
interface usb_rx_byte_ctrl_if;

    logic       rx_start;
    logic       bit_strobe;
    logic       d_bit;
    logic       eop;
    logic       byte_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       pkt_done;
    logic       rx_err;
    logic [1:0] err_code;

    modport master (
        output rx_start, bit_strobe, d_bit, eop, byte_ready,
        input  rx_data, rx_valid, rx_active, pkt_done, rx_err, err_code
    );

    modport slave (
        input  rx_start, bit_strobe, d_bit, eop, byte_ready,
        output rx_data, rx_valid, rx_active, pkt_done, rx_err, err_code
    );

endinterface

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register; resets to all ones.
// SHIFT_MSB=1 shifts toward the MSB, SHIFT_MSB=0 enters new bits at the MSB.
module flex_stp_sr #(
    parameter int unsigned NUM_BITS  = 4,
    parameter bit          SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] r_q;

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            r_q <= '1;
        end else if (shift_enable) begin
            if (SHIFT_MSB)
                r_q <= {r_q[NUM_BITS-2:0], serial_in};
            else
                r_q <= {serial_in, r_q[NUM_BITS-1:1]};
        end
    end

    assign parallel_out = r_q;

endmodule

// File: rtl/usb_rx_byte_ctrl.sv
// USB receive byte controller: SYNC check, byte framing, valid/ready hand-off, error reporting.
// Optional bit-stuff removal is enabled by defining RX_BITSTUFF_EN.
module usb_rx_byte_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              n_rst,
    usb_rx_byte_ctrl_if.slave bus
);

    rx_state_t  r_state;
    rx_state_t  w_next_state;
    logic [2:0] r_bit_cnt;
    logic       r_byte_done;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_active;
    logic       r_pkt_done;
    logic       r_rx_err;
    rx_err_t    r_err_code;

    logic [7:0] w_sr;
    logic       w_in_pkt;
    logic       w_strobe;
    logic       w_drop;
    logic       w_stuff_err;
    logic       w_shift_en;
    logic       w_load;
    logic       w_raise_err;
    logic       w_pkt_done_nxt;
    rx_err_t    w_err_code_nxt;

    // rx_start and eop outrank a coincident strobe, so the bit is not shifted
    assign w_in_pkt   = (r_state == SYNC) || (r_state == RECV);
    assign w_strobe   = bus.bit_strobe & w_in_pkt & ~bus.rx_start & ~bus.eop;
    assign w_shift_en = w_strobe & ~w_drop;

`ifdef RX_BITSTUFF_EN
    logic [2:0] r_ones_cnt;

    assign w_drop      = w_strobe && (r_ones_cnt == 3'(STUFF_LIMIT));
    assign w_stuff_err = w_drop & bus.d_bit;

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst)
            r_ones_cnt <= '0;
        else if (bus.rx_start || w_drop)
            r_ones_cnt <= '0;
        else if (w_shift_en)
            r_ones_cnt <= bus.d_bit ? r_ones_cnt + 3'd1 : '0;
    end
`else
    assign w_drop      = 1'b0;
    assign w_stuff_err = 1'b0;
`endif

    flex_stp_sr #(
        .NUM_BITS  (8),
        .SHIFT_MSB (1'b0)
    ) u_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (w_shift_en),
        .serial_in    (bus.d_bit),
        .parallel_out (w_sr)
    );

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
        end else if (bus.rx_start) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= w_shift_en && (r_bit_cnt == 3'd7);
            if (w_shift_en)
                r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_raise_err    = 1'b0;
        w_pkt_done_nxt = 1'b0;
        w_err_code_nxt = r_err_code;
        if (bus.rx_start) begin
            w_next_state   = SYNC;
            w_err_code_nxt = ERR_SYNC;
        end else begin
            case (r_state)
                IDLE: ;
                SYNC: begin
                    if (bus.eop) begin
                        w_next_state   = ERR;
                        w_raise_err    = 1'b1;
                        w_err_code_nxt = ERR_EOP;
                    end else if (r_byte_done && (w_sr != SYNC_PATTERN)) begin
                        w_next_state   = ERR;
                        w_raise_err    = 1'b1;
                        w_err_code_nxt = ERR_SYNC;
                    end else if (w_stuff_err) begin
                        w_next_state   = ERR;
                        w_raise_err    = 1'b1;
                        w_err_code_nxt = ERR_STUFF;
                    end else if (r_byte_done) begin
                        w_next_state   = RECV;
                    end
                end
                RECV: begin
                    if (bus.eop) begin
                        // a byte still awaiting capture means the EOP arrived mid-frame
                        if ((r_bit_cnt == 3'd0) && !r_byte_done) begin
                            w_next_state   = IDLE;
                            w_pkt_done_nxt = 1'b1;
                        end else begin
                            w_next_state   = ERR;
                            w_raise_err    = 1'b1;
                            w_err_code_nxt = ERR_EOP;
                        end
                    end else begin
                        if (r_byte_done) begin
                            if (!r_rx_valid || bus.byte_ready) begin
                                w_load = 1'b1;
                            end else begin
                                w_raise_err    = 1'b1;
                                w_err_code_nxt = ERR_OVERRUN;
                            end
                        end
                        if (w_stuff_err) begin
                            w_next_state   = ERR;
                            w_raise_err    = 1'b1;
                            w_err_code_nxt = ERR_STUFF;
                        end
                    end
                end
                ERR:     w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_rx_active <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_rx_err    <= 1'b0;
            r_err_code  <= ERR_SYNC;
        end else begin
            r_rx_active <= (w_next_state == SYNC) || (w_next_state == RECV);
            r_pkt_done  <= w_pkt_done_nxt;
            r_rx_err    <= w_raise_err;
            r_err_code  <= w_err_code_nxt;
            if (w_load) begin
                r_rx_data  <= w_sr;
                r_rx_valid <= 1'b1;
            end else if (bus.byte_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.rx_active = r_rx_active;
    assign bus.pkt_done  = r_pkt_done;
    assign bus.rx_err    = r_rx_err;
    assign bus.err_code  = r_err_code;

endmodule

// File: tb/tb_usb_rx_byte_ctrl.sv
// Self-checking bench for usb_rx_byte_ctrl; packet model builds the SYNC+stuffed bit stream from byte lists.
module tb_usb_rx_byte_ctrl;

    logic clk = 1'b0;
    logic n_rst;

    usb_rx_byte_ctrl_if bus();

    usb_rx_byte_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef RX_BITSTUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    int         total = 0;
    int         bad   = 0;
    int         mon_pkt = 0;
    int         mon_err = 0;
    logic [1:0] mon_code = 2'b00;
    logic [7:0] obs_q[$];
    logic [7:0] pkt[$];
    bit         stream[$];
    int         base_obs, base_pkt, base_err;

    // event monitor: accepted bytes, pulse counts, code seen with each rx_err
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.rx_valid && bus.byte_ready) obs_q.push_back(bus.rx_data);
            if (bus.pkt_done) mon_pkt++;
            if (bus.rx_err) begin
                mon_err++;
                mon_code = bus.err_code;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // USB framing model: SYNC byte, LSB-first data, a 0 inserted after every six 1s
    task automatic build_stream(input bit corrupt_stuff);
        logic [7:0] b;
        int ones;
        bit corrupt;
        stream.delete();
        ones = 0;
        corrupt = corrupt_stuff;
        for (int k = -1; k < pkt.size(); k++) begin
            b = (k < 0) ? 8'h80 : pkt[k];
            for (int i = 0; i < 8; i++) begin
                stream.push_back(b[i]);
                ones = b[i] ? ones + 1 : 0;
                if (STUFF_ON && ones == 6) begin
                    stream.push_back(corrupt);
                    corrupt = 1'b0;
                    ones = 0;
                end
            end
        end
    endtask

    task automatic send_bit(input bit b);
        repeat ($urandom_range(0, 3)) tick();
        bus.bit_strobe = 1'b1;
        bus.d_bit      = b;
        tick();
        bus.bit_strobe = 1'b0;
        bus.d_bit      = 1'b0;
    endtask

    task automatic send_stream();
        foreach (stream[i]) send_bit(stream[i]);
    endtask

    task automatic start_pkt();
        base_obs = obs_q.size();
        base_pkt = mon_pkt;
        base_err = mon_err;
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
    endtask

    task automatic send_eop();
        repeat (3) tick();
        bus.eop = 1'b1;
        tick();
        bus.eop = 1'b0;
        repeat (3) tick();
    endtask

    task automatic expect_bytes(input string tag);
        int n;
        n = obs_q.size() - base_obs;
        check({tag, "_count"}, n, pkt.size());
        for (int i = 0; i < pkt.size() && i < n; i++)
            check({tag, "_byte"}, obs_q[base_obs + i], pkt[i]);
    endtask

    task automatic clean_packet(input string tag);
        start_pkt();
        check({tag, "_active"}, bus.rx_active, 1'b1);
        build_stream(1'b0);
        send_stream();
        send_eop();
        expect_bytes(tag);
        check({tag, "_pktdone"}, mon_pkt - base_pkt, 1);
        check({tag, "_noerr"}, mon_err - base_err, 0);
        check({tag, "_idle"}, bus.rx_active, 1'b0);
    endtask

    initial begin
        n_rst = 1'b0;
        bus.rx_start   = 1'b0;
        bus.bit_strobe = 1'b0;
        bus.d_bit      = 1'b0;
        bus.eop        = 1'b0;
        bus.byte_ready = 1'b1;
        #2;
        check("rst_data",   bus.rx_data,   8'h00);
        check("rst_valid",  bus.rx_valid,  1'b0);
        check("rst_active", bus.rx_active, 1'b0);
        check("rst_done",   bus.pkt_done,  1'b0);
        check("rst_err",    bus.rx_err,    1'b0);
        check("rst_code",   bus.err_code,  2'b00);
        #20;
        n_rst = 1'b1;
        tick();

        // directed valid packet
        pkt = '{8'hA5, 8'h3C};
        clean_packet("valid");

        // randomized packets
        for (int p = 0; p < 5; p++) begin
            pkt.delete();
            repeat ($urandom_range(1, 5)) pkt.push_back(8'($urandom));
            if (p == 0) pkt.push_back(8'hFF);
            clean_packet("rand");
        end

        // SYNC mismatch
        start_pkt();
        foreach (pkt[i]) pkt.delete();
        pkt.delete();
        stream = '{1, 0, 0, 0, 0, 0, 0, 1};
        send_stream();
        repeat (4) tick();
        check("sync_err",   mon_err - base_err, 1);
        check("sync_code",  mon_code, 2'b00);
        check("sync_valid", obs_q.size() - base_obs, 0);
        check("sync_idle",  bus.rx_active, 1'b0);

        // misaligned EOP after 3 bits of the second byte
        pkt = '{8'h5A};
        start_pkt();
        build_stream(1'b0);
        send_stream();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_eop();
        expect_bytes("eop");
        check("eop_err",    mon_err - base_err, 1);
        check("eop_code",   mon_code, 2'b10);
        check("eop_nodone", mon_pkt - base_pkt, 0);
        check("eop_idle",   bus.rx_active, 1'b0);

        // overrun: second byte arrives while the first is unaccepted
        bus.byte_ready = 1'b0;
        pkt = '{8'h11, 8'h22};
        start_pkt();
        build_stream(1'b0);
        send_stream();
        repeat (4) tick();
        check("ovr_data",   bus.rx_data, 8'h11);
        check("ovr_valid",  bus.rx_valid, 1'b1);
        check("ovr_err",    mon_err - base_err, 1);
        check("ovr_code",   mon_code, 2'b11);
        check("ovr_active", bus.rx_active, 1'b1);
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;
        check("ovr_clear",  bus.rx_valid, 1'b0);
        send_eop();
        pkt = '{8'h11};
        expect_bytes("ovr");
        check("ovr_done",   mon_pkt - base_pkt, 1);
        bus.byte_ready = 1'b1;

`ifdef RX_BITSTUFF_EN
        // stuffed bit sent as 1
        pkt = '{8'hFF, 8'h00};
        start_pkt();
        build_stream(1'b1);
        send_stream();
        send_eop();
        check("stuff_err",    mon_err - base_err, 1);
        check("stuff_code",   mon_code, 2'b01);
        check("stuff_nodone", mon_pkt - base_pkt, 0);
`endif

        // asynchronous reset mid-RECV after 5 bits
        bus.byte_ready = 1'b0;
        pkt = '{8'h11, 8'h22};
        start_pkt();
        build_stream(1'b0);
        send_stream();
        stream = '{1, 0, 1, 0, 1};
        send_stream();
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_data",   bus.rx_data,   8'h00);
        check("arst_valid",  bus.rx_valid,  1'b0);
        check("arst_active", bus.rx_active, 1'b0);
        check("arst_done",   bus.pkt_done,  1'b0);
        check("arst_err",    bus.rx_err,    1'b0);
        check("arst_code",   bus.err_code,  2'b00);
        #10;
        n_rst = 1'b1;
        bus.byte_ready = 1'b1;
        tick();
        pkt = '{8'hC3, 8'h7E, 8'h01};
        clean_packet("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_rx_byte_ctrl.md
# usb_rx_byte_ctrl

Receive-side byte controller for the USB encryptor's packet receiver. It sequences an 8-bit serial-to-parallel shift register from the NRZI-decoded bit stream: it gates shift enables, removes stuffed bits, checks the SYNC byte, frames bytes, and hands each byte downstream with a valid/ready handshake. It sits between the bit decoder/edge detector and the receive FIFO and decryption path.

## Interface
- SYNC_BYTE, 8'h80, expected first byte after shifting in LSB-first.
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- rx_start  input  1  one-cycle pulse at packet start, from the edge detector.
- bit_strobe  input  1  one-cycle pulse when d_bit is valid.
- d_bit  input  1  NRZI-decoded bit.
- eop  input  1  one-cycle pulse when end of packet (SE0) is detected.
- byte_ready  input  1  downstream accepts rx_data.
- rx_data  output  8  received byte.
- rx_valid  output  1  rx_data holds an unaccepted byte.
- rx_active  output  1  high while in SYNC or RECV.
- pkt_done  output  1  one-cycle pulse on a clean end of packet.
- rx_err  output  1  one-cycle pulse when an error is detected.
- err_code  output  2  last error; 00 sync, 01 stuff, 10 misaligned EOP, 11 overrun. Sticky until the next rx_start.

## Operation
- States: IDLE, SYNC, RECV, ERR.
- IDLE:
  - rx_start → SYNC, clearing bit_cnt and ones_cnt.
  - bit_strobe and eop are ignored.
- Shift path:
  - shift_enable = bit_strobe & (SYNC|RECV) & !drop.
  - Serial input is d_bit, LSB first: the new bit enters the MSB and the register shifts right.
- bit_cnt (3 bits) increments on each shift. It wraps from 7 to 0, and that wrap marks byte complete.
- SYNC:
  - On byte complete, compare the register with SYNC_BYTE. Match → RECV. Mismatch → ERR with code 00.
  - eop in SYNC → ERR with code 10.
- RECV:
  - On byte complete, load the register into rx_data and set rx_valid.
  - eop with bit_cnt==0 and no byte pending capture → pulse pkt_done, go to IDLE.
  - eop with bit_cnt!=0 → ERR with code 10.
- ERR: pulse rx_err, latch err_code, go to IDLE on the next cycle.
- Handshake:
  - rx_valid stays high until a cycle with byte_ready=1, then clears.
  - If a new byte load coincides with byte_ready=1, the new byte loads and rx_valid stays high.
  - If a byte completes while rx_valid=1 and byte_ready=0, the new byte is dropped, rx_data is kept, and err_code=11 with an rx_err pulse. The state stays RECV; the error is reported but not fatal.
- Priority within one cycle: rx_start > eop > bit_strobe.
  - rx_start in any state restarts at SYNC and clears err_code to 00.
  - rx_start does not clear rx_valid.
- Reset mid-packet: all outputs and counters return to their reset values, the state goes to IDLE, and the shift register returns to all ones.

## Timing
- Reset values: rx_data=8'h00; rx_valid, rx_active, pkt_done, rx_err = 0; err_code=2'b00; shift register = 8'hFF.
- shift_enable is combinational in the strobe cycle t. The register updates at the edge ending t.
- Byte complete is registered at t+1. rx_data/rx_valid (or the SYNC compare result) are visible from t+2.
- pkt_done and rx_err are visible the cycle after the eop or error cause.
- rx_active rises the cycle after rx_start and falls on entering IDLE or ERR.

## Configuration
- RX_BITSTUFF_EN defined:
  - ones_cnt (0..6) counts consecutive shifted 1s and clears on a shifted 0.
  - With ones_cnt==6, the next strobed bit is dropped (drop=1, no shift, ones_cnt cleared).
  - If that dropped bit is 1 → ERR with code 01.
- RX_BITSTUFF_EN undefined: drop=0 always, every strobed bit is shifted, ones_cnt is absent, and code 01 is never produced.

## Structure
- Shared package usb_rx_pkg:
  - state enum rx_state_t {IDLE, SYNC, RECV, ERR}.
  - err_code enum rx_err_t.
  - SYNC_BYTE default constant.
  - STUFF_LIMIT=6.
- One sub-module: the existing flex_stp_sr instantiated as NUM_BITS=8, SHIFT_MSB=0, driven by shift_enable and d_bit. Counters, FSM and output registers stay in this block.

## Test plan
- Valid packet:
  - Stimulus: rx_start; bits 0,0,0,0,0,0,0,1; bytes 8'hA5, 8'h3C; eop at a byte boundary; byte_ready=1.
  - Response: rx_data A5 then 3C, each rx_valid one cycle; pkt_done one pulse; rx_err never.
- SYNC mismatch:
  - Stimulus: SYNC bits forming 8'h81.
  - Response: rx_err pulse, err_code=00, state IDLE, no rx_valid.
- Bit stuffing (RX_BITSTUFF_EN):
  - Stimulus: byte 8'hFF sent as 1,1,1,1,1,1,0(stuffed),1,1.
  - Response: rx_data=FF.
  - Variant: stuffed bit sent as 1 → err_code=01.
- Misaligned EOP:
  - Stimulus: eop after 3 bits of a byte.
  - Response: rx_err, err_code=10, no pkt_done, rx_active falls.
- Overrun:
  - Stimulus: byte_ready=0 across two bytes 11, 22.
  - Response: rx_data stays 11, rx_err with err_code=11.
  - Then: byte_ready=1 clears rx_valid.
- Async reset:
  - Stimulus: n_rst low mid-RECV after 5 bits.
  - Response: all outputs at reset values immediately; a fresh packet afterwards decodes correctly.
